piso_tx: RTL and testbench



---
 rtl/piso_tx.sv | 167 ++++++++++++++++
 tb/tb_piso_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, one bit per clk, MSB or LSB first.
// Latency: first bit on serial_out the cycle after the accept edge; frame is WIDTH cycles (WIDTH+1 with parity).
// Backpressure: load_ready only in IDLE or the last frame cycle; optional parity bit via `PISO_PARITY_EN.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             shift_active,
    output logic             frame_done
);

    // Counter is sized to hold 0..WIDTH-1; WIDTH is at least 2 so clog2 is at least 1.
    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("piso_tx: WIDTH must be in 2..32");
    end

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    cnt_q;
    logic             serial_q;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    logic             on_last;      // last data bit is on the line
    logic             frame_end;    // last cycle of the whole frame
    logic             accept;
    logic [WIDTH-1:0] src_word;
    logic             src_bit;
    logic [WIDTH-1:0] src_shifted;

    // Frame-position decode and handshake, all from registered state so
    // load_ready never looks at load_valid.
    always_comb begin
        on_last = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
`ifdef PISO_PARITY_EN
        frame_end = (state_q == ST_PARITY);
`else
        frame_end = on_last;
`endif
        load_ready   = !Rst && ((state_q == ST_IDLE) || frame_end);
        accept       = load_valid && load_ready;
        shift_active = (state_q != ST_IDLE);
        frame_done   = frame_end;
    end

    // One shared shifter: on accept it works on the fresh word so the first
    // bit leaves in the same edge the word is captured; otherwise on the
    // remaining bits of the current word.
    always_comb begin
        src_word = accept ? load_data : shift_q;
        if (MSB_FIRST != 0) begin
            src_bit     = src_word[WIDTH-1];
            src_shifted = {src_word[WIDTH-2:0], 1'b0};
        end else begin
            src_bit     = src_word[0];
            src_shifted = {1'b0, src_word[WIDTH-1:1]};
        end
    end

    // State register; reset wins over any accept on the same edge.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a frame ends either in IDLE or, with a pending accept,
    // straight into the next frame's first bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (on_last) begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                state_d = accept ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture/shift, bit counter and the registered serial line.
    // Any cycle that is not carrying a frame bit drives the line low.
    always_ff @(posedge clk) begin
        if (Rst) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else if (accept) begin
            shift_q  <= src_shifted;
            serial_q <= src_bit;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            par_q    <= ^load_data;
`endif
        end else if ((state_q == ST_SHIFT) && !on_last) begin
            shift_q  <= src_shifted;
            serial_q <= src_bit;
            cnt_q    <= cnt_q + CW'(1);
`ifdef PISO_PARITY_EN
        end else if (on_last) begin
            serial_q <= par_q;
`endif
        end else begin
            serial_q <= 1'b0;
        end
    end

    assign serial_out = serial_q;

`ifndef SYNTHESIS
    // Sanity properties on the output framing.
    always_ff @(posedge clk) begin
        if (!Rst) begin
            assert (!frame_done || shift_active)
                else $error("piso_tx: frame_done outside a frame");
            assert (shift_active || !serial_out)
                else $error("piso_tx: serial_out high while idle");
        end
    end
`endif

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: queue-based bit-stream model checked every cycle against MSB- and LSB-first instances.
// Directed vectors with literal expectations pin the model: reset, single words, back-to-back, mid-frame reset.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W    = 8;
    localparam int LOGN = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] load_data = 8'hFF;
    logic         load_valid = 1'b1;

    logic rdy_m, so_m, act_m, fd_m;
    logic rdy_l, so_l, act_l, fd_l;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .Rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_m), .serial_out(so_m), .shift_active(act_m), .frame_done(fd_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .Rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_l), .serial_out(so_l), .shift_active(act_l), .frame_done(fd_l)
    );

    always #5 clk = ~clk;

    // Model: each line cycle is one entry (bit for MSB-first, bit for LSB-first, last-of-frame flag)
    typedef struct packed {
        logic act;
        logic done;
        logic bm;
        logic bl;
    } ent_t;

    ent_t q[$];
    ent_t cur = '0;
    int   cyc = 0;
    bit   started = 1'b0;

    int checks = 0;
    int failures = 0;

    logic log_so_m [LOGN];
    logic log_so_l [LOGN];
    logic log_fd   [LOGN];
    logic log_rdy  [LOGN];
    logic log_act  [LOGN];

    // Model update: a word accepted while the line is idle or on its final
    // frame cycle becomes the next W (+parity) line cycles.
    always @(posedge clk) begin
        logic m_rdy;
        ent_t e;
        cyc = cyc + 1;
        m_rdy = !rst && (!cur.act || cur.done);
        if (rst) begin
            q.delete();
            cur = '0;
            started = 1'b1;
        end else begin
            if (m_rdy && load_valid) begin
                q.delete();
                for (int i = 0; i < W; i++) begin
                    e.act  = 1'b1;
                    e.bm   = load_data[W-1-i];
                    e.bl   = load_data[i];
                    e.done = (i == W-1) && (PAR == 0);
                    q.push_back(e);
                end
                if (PAR != 0) begin
                    e.act  = 1'b1;
                    e.bm   = ^load_data;
                    e.bl   = ^load_data;
                    e.done = 1'b1;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) cur = q.pop_front();
            else              cur = '0;
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // which: 0 so_m, 1 so_l, 2 frame_done, 3 load_ready, 4 shift_active; first cycle lands in the MSB
    function automatic logic [31:0] seq(input int which, input int t0, input int n);
        logic [31:0] r;
        logic        b;
        r = '0;
        for (int i = 0; i < n; i++) begin
            case (which)
                0:       b = log_so_m[(t0+i) % LOGN];
                1:       b = log_so_l[(t0+i) % LOGN];
                2:       b = log_fd[(t0+i) % LOGN];
                3:       b = log_rdy[(t0+i) % LOGN];
                default: b = log_act[(t0+i) % LOGN];
            endcase
            r = {r[30:0], b};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [W-1:0] d, output int t0);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        t0 = cyc;
        load_valid = 1'b0;
        load_data  = ~d;
    endtask

    logic [W-1:0] tbl [6] = '{8'h5A, 8'h01, 8'hE7, 8'h80, 8'h3C, 8'hFE};

    initial begin
        int t0;

        // Per-cycle compare of both instances against the model
        fork
            forever begin
                @(negedge clk);
                if (started) begin
                    logic er;
                    er = !rst && (!cur.act || cur.done);
                    chk("so_m",  so_m,  cur.bm);
                    chk("so_l",  so_l,  cur.bl);
                    chk("act_m", act_m, cur.act);
                    chk("act_l", act_l, cur.act);
                    chk("fd_m",  fd_m,  cur.done);
                    chk("fd_l",  fd_l,  cur.done);
                    chk("rdy_m", rdy_m, er);
                    chk("rdy_l", rdy_l, er);
                    log_so_m[cyc % LOGN] = so_m;
                    log_so_l[cyc % LOGN] = so_l;
                    log_fd[cyc % LOGN]   = fd_m;
                    log_rdy[cyc % LOGN]  = rdy_m;
                    log_act[cyc % LOGN]  = act_m;
                end
            end
        join_none

        // Reset held 2 cycles with a valid word waiting
        tick();
        @(negedge clk);
        chk("rst_rdy", rdy_m, 1'b0);
        chk("rst_so",  so_m,  1'b0);
        tick();
        rst = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", rdy_m, 1'b1);
        chk("post_rst_so",  so_m,  1'b0);
        chk("post_rst_act", act_m, 1'b0);
        tick();

`ifndef PISO_PARITY_EN
        // Single word A5, MSB first
        send_one(8'hA5, t0);
        repeat (11) tick();
        chkv("a5_bits_m", seq(0, t0, 8), 32'hA5);
        chkv("a5_fd",     seq(2, t0, 9), 32'b000000010);
        chkv("a5_c9_act", seq(4, t0 + 8, 1), 32'h0);
        chkv("a5_c9_so",  seq(0, t0 + 8, 1), 32'h0);

        // Word C1: LSB-first stream 1,0,0,0,0,0,1,1; ready low in cycles 1..7
        send_one(8'hC1, t0);
        repeat (11) tick();
        chkv("c1_bits_l", seq(1, t0, 8), 32'h83);
        chkv("c1_bits_m", seq(0, t0, 8), 32'hC1);
        chkv("c1_rdy",    seq(3, t0, 8), 32'h01);

        // Back-to-back FF then 00 with load_valid held
        load_valid = 1'b1;
        load_data  = 8'hFF;
        tick();
        t0 = cyc;
        load_data = 8'h00;
        repeat (8) tick();
        load_valid = 1'b0;
        load_data  = 8'hAA;
        repeat (11) tick();
        chkv("b2b_bits", seq(0, t0, 16), 32'hFF00);
        chkv("b2b_fd",   seq(2, t0, 16), 32'h0101);
        chkv("b2b_act",  seq(4, t0, 17), 32'h1FFFE);
`else
        // Parity word 07: 0,0,0,0,0,1,1,1 then parity 1; frame is 9 cycles
        send_one(8'h07, t0);
        repeat (12) tick();
        chkv("p07_bits_m", seq(0, t0, 9), 32'h00F);
        chkv("p07_bits_l", seq(1, t0, 9), 32'h1C1);
        chkv("p07_fd",     seq(2, t0, 10), 32'b0000000010);
        chkv("p07_rdy",    seq(3, t0, 9), 32'h001);
        chkv("p07_act",    seq(4, t0, 10), 32'h3FE);
`endif

        // Mid-frame reset during the 4th bit of FF
        send_one(8'hFF, t0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chkv("mrst_bits", seq(0, t0, 4), 32'hF);
        chkv("mrst_c5_so",  seq(0, t0 + 4, 1), 32'h0);
        chkv("mrst_c5_act", seq(4, t0 + 4, 1), 32'h0);
        chkv("mrst_no_fd",  seq(2, t0, 6), 32'h0);

        // New word after the reset
        send_one(8'h80, t0);
        repeat (12) tick();
        chkv("w80_bits_m", seq(0, t0, 8), 32'h80);
        chkv("w80_bits_l", seq(1, t0, 8), 32'h01);

        // Valid held while data churns every cycle; model decides the accepts
        load_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            load_data = tbl[k % 6];
            tick();
        end
        load_valid = 1'b0;
        // Sparse valid pulses, some landing while busy
        for (int k = 0; k < 30; k++) begin
            load_valid = (k % 7 == 0) || (k % 11 == 3);
            load_data  = tbl[(k + 2) % 6];
            tick();
        end
        load_valid = 1'b0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
